// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: table-driven decision-tree classifier walking one node per cycle
module dtree_seq_eval #(
  parameter int N_FEAT = 9,
  parameter int FEAT_W = 8,
  parameter int CLS_W = 2,
  parameter int NODES = 64,
  parameter int MAX_DEPTH = 16,
  localparam int NA_W = $clog2(NODES),
  localparam int FI_W = $clog2(N_FEAT),
  localparam int PR_W = $clog2(FEAT_W + 1),
  localparam int DP_W = $clog2(MAX_DEPTH + 1),
  localparam int CFG_W = 1 + FI_W + PR_W + FEAT_W + 2 * NA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [NA_W-1:0]          cfg_addr,
  input  logic [CFG_W-1:0]         cfg_data,
  output logic                     cfg_busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLS_W-1:0]         out_class,
  output logic [DP_W-1:0]          out_depth,
  output logic                     out_err
);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  localparam logic [PR_W-1:0] FW = PR_W'(FEAT_W);
  localparam logic [FI_W-1:0] NF = FI_W'(N_FEAT);
  localparam logic [DP_W-1:0] MD = DP_W'(MAX_DEPTH);
  state_t state;
  logic [CFG_W-1:0] mem [NODES];
  logic [N_FEAT*FEAT_W-1:0] feat;
  logic [FEAT_W-1:0] fa [N_FEAT];
  logic [NA_W-1:0] ptr, lptr, rptr;
  logic [DP_W-1:0] depth;
  logic leaf, bad, go;
  logic [FI_W-1:0] fidx;
  logic [PR_W-1:0] prec, p;
  logic [FEAT_W-1:0] thr, fx, tm;
  for (genvar i = 0; i < N_FEAT; i++) begin : g_fa
    assign fa[i] = feat[i*FEAT_W +: FEAT_W];
  end
  assign {leaf, fidx, prec, thr, lptr, rptr} = mem[ptr];
  assign in_ready = state == IDLE;
  assign cfg_busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_depth = depth;
  always_comb begin
    bad = fidx >= NF || depth == MD;
    p = (prec == '0 || prec > FW) ? FW : prec;
    fx = fa[fidx < NF ? fidx : '0];
    tm = thr & ~({FEAT_W{1'b1}} << p);
    go = (fx >> (FW - p)) <= tm;
  end
  always_ff @(posedge clk)
    if (cfg_we && state == IDLE) mem[cfg_addr] <= cfg_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      feat <= '0;
      ptr <= '0;
      depth <= '0;
      out_class <= '0;
      out_err <= 1'b0;
    end else
      unique case (state)
        IDLE:
          if (in_valid) begin
            feat <= in_feat;
            ptr <= '0;
            depth <= '0;
            state <= WALK;
          end
        WALK:
          if (leaf) begin
            out_class <= thr[CLS_W-1:0];
            out_err <= 1'b0;
            state <= DONE;
          end else if (bad) begin
            out_class <= '0;
            out_err <= 1'b1;
            state <= DONE;
          end else begin
            depth <= depth + 1'b1;
            ptr <= go ? lptr : rptr;
          end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: directed bench with a tree-walk reference model
module tb_dtree_seq_eval;
  logic clk = 0, rst = 1, cfg_we = 0, in_valid = 0, out_ready = 0;
  logic [5:0] cfg_addr = '0;
  logic [28:0] cfg_data = '0;
  logic [71:0] in_feat = '0;
  logic cfg_busy, in_ready, out_valid, out_err;
  logic [1:0] out_class;
  logic [4:0] out_depth;
  int checks = 0, errors = 0;
  int exp_cls = 0, exp_dep = 0, exp_err = 0, cyc = 0, acc = 0;
  bit exp_ok = 0;
  typedef struct {bit leaf; int fidx, prec, thr, l, r;} node_t;
  node_t tbl[64];

  dtree_seq_eval dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_depth(out_depth), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic logic [71:0] fv(input int idx, input logic [7:0] v);
    logic [71:0] f = '0;
    f[idx*8 +: 8] = v;
    return f;
  endfunction

  // Reference walk: follows the node table with plain integer arithmetic
  function automatic void model(input logic [71:0] f);
    int ptr = 0, d = 0, p, x;
    exp_err = 1;
    exp_cls = 0;
    for (int s = 0; s < 100; s++) begin
      if (tbl[ptr].leaf) begin
        exp_cls = tbl[ptr].thr % 4;
        exp_err = 0;
        break;
      end
      if (tbl[ptr].fidx >= 9 || d == 16) break;
      p = (tbl[ptr].prec == 0 || tbl[ptr].prec > 8) ? 8 : tbl[ptr].prec;
      x = int'(f[tbl[ptr].fidx*8 +: 8]);
      ptr = ((x >> (8 - p)) <= tbl[ptr].thr % (1 << p)) ? tbl[ptr].l : tbl[ptr].r;
      d++;
    end
    exp_dep = d;
  endfunction

  always @(negedge clk)
    if (!rst) begin
      chk("ready_vs_busy", 32'(in_ready), 32'(!cfg_busy));
      if (out_valid) begin
        chk("valid_expected", 32'(exp_ok), 1);
        chk("class", 32'(out_class), exp_cls);
        chk("depth", 32'(out_depth), exp_dep);
        chk("err", 32'(out_err), exp_err);
        chk("ready_in_done", 32'(in_ready), 0);
      end
    end

  task automatic setw(input int a, input bit leaf, input int fidx, prec, thr, l, r, input bit lands);
    cfg_we = 1;
    cfg_addr = 6'(a);
    cfg_data = {leaf, 4'(fidx), 4'(prec), 8'(thr), 6'(l), 6'(r)};
    if (lands) tbl[a] = '{leaf, fidx, prec, thr, l, r};
  endtask

  task automatic wr(input int a, input bit leaf, input int fidx, prec, thr, l, r);
    setw(a, leaf, fidx, prec, thr, l, r, 1);
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic start(input logic [71:0] f);
    int t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ready_wait", 32'(in_ready), 1);
    in_valid = 1;
    in_feat = f;
    model(f);
    exp_ok = 1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
  endtask

  task automatic fin(input int hold, input int ecls, edep, eerr);
    while (!out_valid && cyc - acc < 60) begin @(posedge clk); #1; end
    chk("latency", cyc - acc, exp_dep + 1);
    if (ecls >= 0) begin
      chk("lit_class", 32'(out_class), ecls);
      chk("lit_depth", 32'(out_depth), edep);
      chk("lit_err", 32'(out_err), eerr);
    end
    repeat (hold) begin in_valid = 1; @(posedge clk); #1; end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    exp_ok = 0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_idle", 32'(cfg_busy), 0);
  endtask

  task automatic go(input logic [71:0] f, input int hold, ecls, edep, eerr);
    start(f);
    fin(hold, ecls, edep, eerr);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_class", 32'(out_class), 0);
    chk("rst_depth", 32'(out_depth), 0);
    chk("rst_err", 32'(out_err), 0);
    rst = 0;
    wr(0, 1, 0, 0, 3, 0, 0);
    go(72'h0, 0, 3, 0, 0);
    wr(0, 0, 2, 2, 0, 1, 2);
    wr(1, 1, 0, 0, 1, 0, 0);
    wr(2, 1, 0, 0, 2, 0, 0);
    go(fv(2, 8'h3F), 0, 1, 1, 0);
    go(fv(2, 8'h40), 0, 2, 1, 0);
    wr(0, 0, 7, 3, 1, 1, 2);
    go(fv(7, 8'h3F), 0, 1, 1, 0);
    go(fv(7, 8'h40), 0, 2, 1, 0);
    wr(0, 0, 7, 0, 'h80, 1, 2);
    go(fv(7, 8'h80), 0, 1, 1, 0);
    go(fv(7, 8'h81), 0, 2, 1, 0);
    wr(0, 0, 7, 9, 'h80, 1, 2);
    go(fv(7, 8'h80), 0, 1, 1, 0);
    wr(0, 0, 0, 8, 'hFF, 0, 0);
    go(72'h0, 0, 0, 16, 1);
    wr(0, 0, 12, 0, 0, 1, 2);
    go(72'h0, 0, 0, 0, 1);
    wr(0, 0, 2, 2, 0, 1, 2);
    go(fv(2, 8'h40), 5, 2, 1, 0);
    start(fv(2, 8'h3F));
    setw(1, 1, 0, 0, 3, 0, 0, 0);
    @(posedge clk); #1;
    cfg_we = 0;
    fin(0, 1, 1, 0);
    go(fv(2, 8'h3F), 0, 1, 1, 0);
    setw(2, 1, 0, 0, 0, 0, 0, 1);
    start(fv(2, 8'h40));
    cfg_we = 0;
    fin(0, 0, 1, 0);
    wr(2, 1, 0, 0, 2, 0, 0);
    wr(0, 0, 0, 8, 'hFF, 0, 0);
    start(72'h0);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_busy", 32'(cfg_busy), 0);
    exp_ok = 0;
    @(posedge clk); #1;
    rst = 0;
    wr(0, 0, 2, 2, 0, 1, 2);
    go(fv(2, 8'h3F), 0, 1, 1, 0);
    wr(0, 0, 0, 4, 7, 1, 2);
    wr(1, 0, 1, 8, 100, 3, 4);
    wr(2, 0, 8, 0, 200, 5, 6);
    for (int i = 3; i < 7; i++) wr(i, 1, 0, 0, i - 3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      start({8'($urandom), 32'($urandom), 32'($urandom)});
      fin(i % 3, -1, 0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
